hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall / flush / freeze control for a 5-stage core.
// A small FSM (RUN / MEM_WAIT / HALT) tracks data-memory accesses.
// Stage-register enables, flush and bubble are driven combinationally from the
// FSM state and the current hazard inputs.
// Optional feature: define STALL_COUNT_EN to add a saturating 16-bit
// stall_count output. It counts cycles in which the PC is held.
module hazard_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ID_valid,
  input  logic [1:0] ID_addr_a,
  input  logic [1:0] ID_addr_b,
  input  logic       ID_use_a,
  input  logic       ID_use_b,
  input  logic [1:0] EX_addr_write,
  input  logic       EX_sig_write,
  input  logic       EX_is_load,
  input  logic       EX_branch_taken,
  input  logic       DM_req,
  input  logic       DM_ack,
  output logic       PC_enable,
  output logic       IF_ID_enable,
  output logic       ID_EX_enable,
  output logic       EX_DM_enable,
  output logic       DM_WB_enable,
  output logic       IF_ID_flush,
  output logic       ID_EX_bubble,
  output logic       bus_error,
  output logic [1:0] ctrl_state
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  state_t     state, state_nx;
  logic [3:0] wait_cnt;
  logic       frozen;
  logic       load_use;
  logic       mem_stall_start;
  logic       timeout;

  // Hazard decode.
  // A memory access that is not acknowledged in the same cycle stalls the
  // whole pipe. A load feeding the very next instruction costs one bubble.
  always_comb begin
    mem_stall_start = (state == RUN) && DM_req && !DM_ack;
    timeout         = (state == MEM_WAIT) && !DM_ack && (wait_cnt == 4'hF);
    frozen          = (state == HALT) || mem_stall_start ||
                      ((state == MEM_WAIT) && !DM_ack);
    load_use        = EX_is_load && EX_sig_write && ID_valid &&
                      ((ID_use_a && (ID_addr_a == EX_addr_write)) ||
                       (ID_use_b && (ID_addr_b == EX_addr_write)));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  // Next-state logic. HALT is left only through reset.
  always_comb begin
    state_nx = state;
    case (state)
      RUN:      if (mem_stall_start) state_nx = MEM_WAIT;
      MEM_WAIT: begin
        if (DM_ack)       state_nx = RUN;
        else if (timeout) state_nx = HALT;
      end
      HALT:     state_nx = HALT;
      default:  state_nx = RUN;
    endcase
  end

  // Wait counter.
  // The first stalled cycle, which is still in RUN, loads 1. The counter then
  // reaches 15 on the 15th MEM_WAIT cycle, which is the 16th frozen cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        RUN:      if (mem_stall_start) wait_cnt <= 4'd1;
        MEM_WAIT: begin
          if (DM_ack)                 wait_cnt <= 4'd0;
          else if (wait_cnt != 4'hF)  wait_cnt <= wait_cnt + 4'd1;
        end
        default:  wait_cnt <= wait_cnt;
      endcase
    end
  end

  // Sticky timeout flag. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bus_error <= 1'b0;
    else if (timeout) bus_error <= 1'b1;
  end

  // Stage controls, in priority order: reset, freeze, branch, load-use, normal.
  // During a freeze the branch or load-use condition stays in the frozen
  // stage registers, so it is acted on in the first unfrozen cycle.
  always_comb begin
    PC_enable    = 1'b0;
    IF_ID_enable = 1'b0;
    ID_EX_enable = 1'b0;
    EX_DM_enable = 1'b0;
    DM_WB_enable = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    if (!rst_n) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (frozen) begin
      PC_enable    = 1'b0;
    end else if (EX_branch_taken) begin
      PC_enable    = 1'b1;
      IF_ID_enable = 1'b1;
      ID_EX_enable = 1'b1;
      EX_DM_enable = 1'b1;
      DM_WB_enable = 1'b1;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (load_use) begin
      ID_EX_enable = 1'b1;
      EX_DM_enable = 1'b1;
      DM_WB_enable = 1'b1;
      ID_EX_bubble = 1'b1;
    end else begin
      PC_enable    = 1'b1;
      IF_ID_enable = 1'b1;
      ID_EX_enable = 1'b1;
      EX_DM_enable = 1'b1;
      DM_WB_enable = 1'b1;
    end
  end

  assign ctrl_state = state;

`ifdef STALL_COUNT_EN
  // Count cycles in which the PC is held, saturating at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= 16'd0;
    else if (!PC_enable && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule
